// File: rtl/alu_16.sv
// alu_16 -- single-cycle 16-bit ALU with registered result and status flags.
//
// Operands X/Y and op_code are sampled on the rising clk edge when in_valid
// is high; the result appears on Z (with flags) one clock later, and
// out_valid marks that cycle. While in_valid is low Z and flags hold.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset, clears Z/flags/out_valid
//   X, Y       16-bit operands (two's complement for add/sub/negate flags)
//   op_code    4-bit operation select
//   in_valid   sample operands this cycle
//   Z          registered result
//   out_valid  high for the cycle after an accepted in_valid
//   flags      registered {C, V, N, Zf}
//
// Build option
//   ALU_FLAGS_EN  when defined, flags are computed; when undefined, the flags
//                 port stays present but is tied to 4'b0000 and no flag logic
//                 exists.
module alu_16 #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] X,
   input  logic [DATA_W-1:0] Y,
   input  logic [3:0]        op_code,
   input  logic              in_valid,
   output logic [DATA_W-1:0] Z,
   output logic              out_valid,
   output logic [3:0]        flags
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_CLR  = 4'b0010;
   localparam logic [3:0] OP_SHLX = 4'b0011;
   localparam logic [3:0] OP_SHRX = 4'b0100;
   localparam logic [3:0] OP_LAND = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_NEGX = 4'b1000;
   localparam logic [3:0] OP_NEGY = 4'b1001;
   localparam logic [3:0] OP_SHRY = 4'b1010;
   localparam logic [3:0] OP_SHLY = 4'b1011;
   localparam logic [3:0] OP_XOR  = 4'b1100;
   localparam logic [3:0] OP_NOTX = 4'b1101;

   logic signed [DATA_W-1:0] x_s_p0;
   logic signed [DATA_W-1:0] y_s_p0;
   logic signed [DATA_W-1:0] neg_x_p0;
   logic signed [DATA_W-1:0] neg_y_p0;
   logic        [DATA_W:0]   sum_p0;
   logic        [DATA_W:0]   dif_p0;
   logic        [DATA_W-1:0] res_p0;

   logic        [DATA_W-1:0] z_p1;
   logic                     vld_p1;

   // ---- stage p0: combinational result from sampled-to-be operands ----
   assign x_s_p0   = signed'(X);
   assign y_s_p0   = signed'(Y);
   assign neg_x_p0 = -x_s_p0;
   assign neg_y_p0 = -y_s_p0;
   // Extra MSB carries the add carry-out and, for sub, the borrow (X < Y).
   assign sum_p0   = {1'b0, X} + {1'b0, Y};
   assign dif_p0   = {1'b0, X} - {1'b0, Y};

   always_comb begin
      res_p0 = '0;
      case (op_code)
         OP_ADD:  res_p0 = sum_p0[DATA_W-1:0];
         OP_SUB:  res_p0 = dif_p0[DATA_W-1:0];
         OP_CLR:  res_p0 = '0;
         OP_SHLX: res_p0 = {X[DATA_W-2:0], 1'b0};
         OP_SHRX: res_p0 = {1'b0, X[DATA_W-1:1]};
         OP_LAND: res_p0 = {{(DATA_W-1){1'b0}}, ((|X) && (|Y))};
         OP_AND:  res_p0 = X & Y;
         OP_OR:   res_p0 = X | Y;
         OP_NEGX: res_p0 = neg_x_p0;
         OP_NEGY: res_p0 = neg_y_p0;
         OP_SHRY: res_p0 = {1'b0, Y[DATA_W-1:1]};
         OP_SHLY: res_p0 = {Y[DATA_W-2:0], 1'b0};
         OP_XOR:  res_p0 = X ^ Y;
         OP_NOTX: res_p0 = ~X;
         default: res_p0 = '0;
      endcase
   end

   // ---- stage p1: result and valid registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         z_p1   <= '0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            z_p1 <= res_p0;
         end
      end
   end

   assign Z         = z_p1;
   assign out_valid = vld_p1;

`ifdef ALU_FLAGS_EN
   // Signed overflow: operands of equal sign producing a result of the other sign.
   function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
      return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
   endfunction

   // Signed overflow for a - b: operands of differing sign, result sign flips from a.
   function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
      return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
   endfunction

   // Only the most negative value has no positive counterpart.
   function automatic logic neg_ovf(input logic signed [DATA_W-1:0] a);
      return a == {1'b1, {(DATA_W-1){1'b0}}};
   endfunction

   logic       c_p0;
   logic       v_p0;
   logic [3:0] flags_p1;

   // ---- stage p0: carry / overflow ----
   always_comb begin
      c_p0 = 1'b0;
      v_p0 = 1'b0;
      case (op_code)
         OP_ADD: begin
            c_p0 = sum_p0[DATA_W];
            v_p0 = add_ovf(x_s_p0, y_s_p0, signed'(sum_p0[DATA_W-1:0]));
         end
         OP_SUB: begin
            c_p0 = dif_p0[DATA_W];
            v_p0 = sub_ovf(x_s_p0, y_s_p0, signed'(dif_p0[DATA_W-1:0]));
         end
         OP_SHLX: c_p0 = X[DATA_W-1];
         OP_SHRX: c_p0 = X[0];
         OP_SHLY: c_p0 = Y[DATA_W-1];
         OP_SHRY: c_p0 = Y[0];
         OP_NEGX: v_p0 = neg_ovf(x_s_p0);
         OP_NEGY: v_p0 = neg_ovf(y_s_p0);
         default: begin
            c_p0 = 1'b0;
            v_p0 = 1'b0;
         end
      endcase
   end

   // ---- stage p1: flag register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_p1 <= 4'b0000;
      end else if (in_valid) begin
         flags_p1 <= {c_p0, v_p0, res_p0[DATA_W-1], (res_p0 == '0)};
      end
   end

   assign flags = flags_p1;
`else
   assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: a driver issues operations and pushes the
// reference-model result into a queue; a monitor on the falling edge pops and
// compares whenever out_valid is high and checks hold behaviour otherwise.
module tb_alu_16;

   logic        clk;
   logic        rst_n;
   logic [15:0] X;
   logic [15:0] Y;
   logic [3:0]  op_code;
   logic        in_valid;
   logic [15:0] Z;
   logic        out_valid;
   logic [3:0]  flags;

   typedef struct {
      logic [15:0] z;
      logic [3:0]  f;
   } exp_t;

   exp_t        q[$];
   int          n_total = 0;
   int          n_pass  = 0;
   bit          mon_en  = 0;
   logic [15:0] hold_z  = '0;
   logic [3:0]  hold_f  = '0;

   alu_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .X         (X),
      .Y         (Y),
      .op_code   (op_code),
      .in_valid  (in_valid),
      .Z         (Z),
      .out_valid (out_valid),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      int   ux, uy, sx, sy, r, s;
      bit   c, v;
      exp_t e;
      ux = int'(x);
      uy = int'(y);
      sx = int'(signed'(x));
      sy = int'(signed'(y));
      r = 0; c = 0; v = 0;
      case (op)
         4'd0:  begin r = ux + uy; c = (r > 65535); s = sx + sy; v = (s > 32767) || (s < -32768); end
         4'd1:  begin r = ux - uy; c = (ux < uy); s = sx - sy; v = (s > 32767) || (s < -32768); end
         4'd2:  r = 0;
         4'd3:  begin r = ux * 2; c = (ux >= 32768); end
         4'd4:  begin r = ux / 2; c = (ux % 2) == 1; end
         4'd5:  r = (ux != 0 && uy != 0) ? 1 : 0;
         4'd6:  r = int'(x & y);
         4'd7:  r = int'(x | y);
         4'd8:  begin r = -sx; v = (-sx > 32767); end
         4'd9:  begin r = -sy; v = (-sy > 32767); end
         4'd10: begin r = uy / 2; c = (uy % 2) == 1; end
         4'd11: begin r = uy * 2; c = (uy >= 32768); end
         4'd12: r = int'(x ^ y);
         4'd13: r = int'(~x);
         default: r = 0;
      endcase
      e.z = 16'(r);
`ifdef ALU_FLAGS_EN
      e.f = {c, v, e.z[15], (e.z == 16'h0000)};
`else
      e.f = 4'b0000;
`endif
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      @(posedge clk);
      #1;
      X = x; Y = y; op_code = op; in_valid = 1'b1;
      q.push_back(model(op, x, y));
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      X = 16'($urandom); Y = 16'($urandom); op_code = 4'($urandom);
   endtask

   function automatic logic [15:0] pick();
      logic [15:0] corners [5];
      corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
      corners[3] = 16'h8000; corners[4] = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return 16'($urandom);
   endfunction

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (out_valid === 1'b1) begin
               if (q.size() == 0) begin
                  check("unexpected_out_valid", 32'(out_valid), 32'd0);
               end else begin
                  e = q.pop_front();
                  check("Z", 32'(Z), 32'(e.z));
                  check("flags", 32'(flags), 32'(e.f));
                  hold_z = e.z;
                  hold_f = e.f;
               end
            end else begin
               check("hold_Z", 32'(Z), 32'(hold_z));
               check("hold_flags", 32'(flags), 32'(hold_f));
            end
         end
      end
   end

   // Driver
   initial begin
      exp_t e;
      rst_n = 1'b1; in_valid = 1'b0; X = '0; Y = '0; op_code = '0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_Z", 32'(Z), 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      #10 rst_n = 1'b1;           // released between edges
      mon_en = 1'b1;

      // Directed vectors
      issue(4'b0000, 16'h0005, 16'h0002);
      issue(4'b0000, 16'h0184, 16'h017A);
      issue(4'b0000, 16'h7FFF, 16'h0001);
      issue(4'b0001, 16'h7FFF, 16'h0001);
      issue(4'b1000, 16'h7FFF, 16'h0000);
      issue(4'b0001, 16'h8000, 16'h0001);
      issue(4'b1000, 16'h8000, 16'h0000);
      issue(4'b1001, 16'h0000, 16'h8000);
      issue(4'b0001, 16'h0001, 16'h0002);
      issue(4'b0000, 16'hFFFF, 16'h0001);
      issue(4'b0110, 16'h69FD, 16'h401D);
      issue(4'b0101, 16'h69FD, 16'h401D);
      issue(4'b0101, 16'h0000, 16'h401D);
      issue(4'b0111, 16'h69FD, 16'h8003);
      issue(4'b0100, 16'hC1F9, 16'h8003);
      issue(4'b0011, 16'hC1F9, 16'h8003);
      issue(4'b1010, 16'hC1F9, 16'h8003);
      issue(4'b1011, 16'hC1F9, 16'h8003);
      issue(4'b0010, 16'hC1F9, 16'h8003);
      issue(4'b1100, 16'hC1F9, 16'h8003);
      issue(4'b1101, 16'hC1F9, 16'h8003);
      issue(4'b1110, 16'hC1F9, 16'h8003);
      issue(4'b1111, 16'hC1F9, 16'h8003);
      for (int i = 0; i < 3; i++) idle();

      // Randomised traffic with gaps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         else issue(4'($urandom), pick(), pick());
      end
      idle();
      idle();

      // Reset between edges with an operation pending
      mon_en = 1'b0;
      X = 16'h1234; Y = 16'h1111; op_code = 4'b0000; in_valid = 1'b1;
      @(posedge clk);
      #3;
      X = 16'h0005; Y = 16'h0003; op_code = 4'b0001;
      rst_n = 1'b0;
      #1;
      check("async_reset_Z", 32'(Z), 32'd0);
      check("async_reset_flags", 32'(flags), 32'd0);
      check("async_reset_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      hold_z = '0;
      hold_f = '0;
      e = model(4'b0001, 16'h0005, 16'h0003);
      q.push_back(e);
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) idle();
      @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
